// File: rtl/wave_display.sv
// Waveform renderer: reads the idle half of the 512x8 capture RAM and draws the
// sample trace into a 1024x512 window of the VGA raster, two cycles behind x/y.
module wave_display #(
    parameter logic [23:0] FG_COLOR = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR = 24'h000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] x,
    input  logic [9:0]  y,
    input  logic        valid,
    input  logic        read_index,
    input  logic [7:0]  read_value,
    output logic [8:0]  read_address,
    output logic        valid_pixel,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        wave_display_idle
);

    typedef enum logic {
        DRAWING = 1'b0,
        IDLE    = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        shown_index_q, shown_index_d;

    logic        win1_q, win1_d;
    logic [9:0]  x1_q, x1_d;
    logic [7:0]  row1_q, row1_d;

    logic [7:0]  cur_q, cur_d;
    logic [7:0]  prev_q, prev_d;
    logic        valid_pixel_q, valid_pixel_d;
    logic [23:0] rgb_q, rgb_d;

    logic        frame_start;
    logic        in_window;
    logic        strobe;
    logic [7:0]  row8;
    logic [7:0]  lo, hi;
    logic        lit;

    // Only y[8:1] selects an 8-bit row; y[0] merely doubles each row.
    logic        unused_y0;
    assign unused_y0 = y[0];

    assign frame_start  = valid && (x == 11'd0) && (y == 10'd0);
    assign in_window    = valid && !x[10] && !y[9];
    assign read_address = {shown_index_q, x[9:2]};

    always_comb begin
        shown_index_d = shown_index_q;
        if (frame_start) begin
            shown_index_d = read_index;
        end
        win1_d = in_window;
        x1_d   = x[9:0];
        row1_d = y[8:1];
    end

    // Sample registers advance once per 4-column group; the first group of a
    // row seeds both so no segment is drawn from the previous row's last sample.
    always_comb begin
        strobe = win1_q && (x1_q[1:0] == 2'd0);
        prev_d = prev_q;
        cur_d  = cur_q;
        if (strobe) begin
            prev_d = (x1_q == 10'd0) ? read_value : cur_q;
            cur_d  = read_value;
        end
    end

    always_comb begin
        row8          = 8'd255 - row1_q;
        lo            = (prev_d < cur_d) ? prev_d : cur_d;
        hi            = (prev_d < cur_d) ? cur_d : prev_d;
        lit           = (row8 >= lo) && (row8 <= hi);
        valid_pixel_d = win1_q;
        rgb_d         = 24'd0;
        if (win1_q) begin
            rgb_d = lit ? FG_COLOR : BG_COLOR;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DRAWING: if (valid && y[9]) state_d = IDLE;
            IDLE:    if (frame_start)   state_d = DRAWING;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            shown_index_q <= 1'b0;
            win1_q        <= 1'b0;
            x1_q          <= 10'd0;
            row1_q        <= 8'd0;
            cur_q         <= 8'd0;
            prev_q        <= 8'd0;
            valid_pixel_q <= 1'b0;
            rgb_q         <= 24'd0;
        end else begin
            state_q       <= state_d;
            shown_index_q <= shown_index_d;
            win1_q        <= win1_d;
            x1_q          <= x1_d;
            row1_q        <= row1_d;
            cur_q         <= cur_d;
            prev_q        <= prev_d;
            valid_pixel_q <= valid_pixel_d;
            rgb_q         <= rgb_d;
        end
    end

    assign valid_pixel       = valid_pixel_q;
    assign r                 = rgb_q[23:16];
    assign g                 = rgb_q[15:8];
    assign b                 = rgb_q[7:0];
    assign wave_display_idle = (state_q == IDLE);

endmodule

// File: tb/tb_wave_display.sv
// Bench for wave_display: a synchronous RAM model feeds the DUT, a reference
// pixel model fills a scoreboard, and feature tasks check index and idle logic.
module tb_wave_display;

    localparam logic [23:0] FG = 24'hF0E0D0;
    localparam logic [23:0] BG = 24'h102030;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] x;
    logic [9:0]  y;
    logic        valid;
    logic        read_index;
    logic [7:0]  read_value;
    logic [8:0]  read_address;
    logic        valid_pixel;
    logic [7:0]  r, g, b;
    logic        wave_display_idle;

    logic [7:0]  ram [0:255];
    logic [24:0] sb [$];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    wave_display #(.FG_COLOR(FG), .BG_COLOR(BG)) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .valid(valid),
        .read_index(read_index), .read_value(read_value),
        .read_address(read_address), .valid_pixel(valid_pixel),
        .r(r), .g(g), .b(b), .wave_display_idle(wave_display_idle)
    );

    // Both RAM halves hold the same data, so only the low 8 address bits matter.
    always_ff @(posedge clk) read_value <= ram[read_address[7:0]];

    // Reference pixel, assuming each row is scanned contiguously from x=0.
    function automatic logic [24:0] model(input int xi, input int yi, input bit vi);
        int s;
        logic [7:0] c, p, lo, hi, row8;
        if (!(vi && xi < 1024 && yi < 512)) return 25'd0;
        s    = xi / 4;
        c    = ram[s];
        p    = (s == 0) ? c : ram[s-1];
        lo   = (p < c) ? p : c;
        hi   = (p < c) ? c : p;
        row8 = 8'(255 - yi / 2);
        return {1'b1, ((row8 >= lo) && (row8 <= hi)) ? FG : BG};
    endfunction

    task automatic step(input int xi, input int yi, input bit vi);
        logic [24:0] e;
        sb.push_back(model(xi, yi, vi));
        x     = 11'(xi);
        y     = 10'(yi);
        valid = vi;
        @(posedge clk);
        #1;
        if (sb.size() > 1) begin
            e = sb.pop_front();
            checks++;
            if ({valid_pixel, r, g, b} !== e) begin
                errors++;
                $display("FAIL pixel x=%0d y=%0d: got %h want %h", x, y, {valid_pixel, r, g, b}, e);
            end
        end
    endtask

    task automatic scan_row(input int yi);
        for (int xi = 0; xi < 1032; xi++) step(xi, yi, 1'b1);
        step(1032, yi, 1'b0);
        step(1033, yi, 1'b0);
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 256; i++) ram[i] = v;
    endtask

    task automatic check_idx(input string tag, input logic want);
        checks++;
        if (read_address[8] !== want) begin
            errors++;
            $display("FAIL %s read_address[8]: got %b want %b", tag, read_address[8], want);
        end
    endtask

    task automatic check_idle(input string tag, input logic want);
        checks++;
        if (wave_display_idle !== want) begin
            errors++;
            $display("FAIL %s idle: got %b want %b", tag, wave_display_idle, want);
        end
    endtask

    task automatic test_reset(input int xs, input int yi);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb.delete();
            step(xs + i, yi, 1'b1);
            checks++;
            if ({wave_display_idle, valid_pixel, r, g, b} !== {2'b10, 24'd0}) begin
                errors++;
                $display("FAIL reset outputs: got idle=%b vp=%b rgb=%h want idle=1 vp=0 rgb=0",
                         wave_display_idle, valid_pixel, {r, g, b});
            end
            checks++;
            if (read_address !== {1'b0, 8'((xs + i) / 4)}) begin
                errors++;
                $display("FAIL reset read_address: got %h want %h", read_address, {1'b0, 8'((xs + i) / 4)});
            end
        end
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic test_flat;
        int rows [10] = '{1, 2, 200, 253, 254, 255, 256, 257, 510, 511};
        fill(8'h80);
        read_index = 1'b1;
        scan_row(0);
        check_idx("flat frame start", 1'b1);
        check_idle("flat frame start", 1'b0);
        foreach (rows[i]) begin
            scan_row(rows[i]);
            check_idx("flat row", 1'b1);
        end
    endtask

    task automatic test_ramp;
        int rows [8] = '{125, 126, 127, 250, 381, 382, 383, 384};
        fill(8'h40);
        ram[100] = 8'hC0;
        foreach (rows[i]) scan_row(rows[i]);
    endtask

    task automatic test_row_start;
        int rows [5] = '{0, 1, 2, 3, 300};
        fill(8'h80);
        ram[255] = 8'h00;
        ram[0]   = 8'hFF;
        foreach (rows[i]) scan_row(rows[i]);
    endtask

    task automatic test_index_toggle;
        read_index = 1'b0;
        step(0, 512, 1'b1);
        scan_row(0);
        check_idx("toggle frame start", 1'b0);
        for (int xi = 0; xi < 1032; xi++) begin
            if (xi == 500) read_index = 1'b1;
            step(xi, 200, 1'b1);
            if (xi == 600) check_idx("toggle mid-row", 1'b0);
        end
        scan_row(201);
        check_idx("toggle later row", 1'b0);
        step(0, 512, 1'b1);
        step(0, 0, 1'b1);
        check_idx("toggle new frame", 1'b1);
        scan_row(1);
        check_idx("toggle new frame row", 1'b1);
    endtask

    task automatic test_idle;
        scan_row(0);
        check_idle("drawing", 1'b0);
        step(5, 700, 1'b0);
        check_idle("invalid y>=512", 1'b0);
        step(0, 511, 1'b1);
        check_idle("y=511", 1'b0);
        step(0, 512, 1'b1);
        check_idle("y=512", 1'b1);
        step(0, 0, 1'b0);
        check_idle("invalid origin", 1'b1);
        step(10, 600, 1'b1);
        check_idle("blanking", 1'b1);
        step(0, 0, 1'b1);
        check_idle("origin", 1'b0);
        scan_row(1);
    endtask

    task automatic test_reset_mid;
        read_index = 1'b1;
        step(0, 512, 1'b1);
        scan_row(0);
        check_idx("pre-reset", 1'b1);
        for (int xi = 0; xi <= 300; xi++) step(xi, 100, 1'b1);
        test_reset(301, 100);
        scan_row(101);
        check_idle("after reset row", 1'b1);
        check_idx("after reset row", 1'b0);
        scan_row(0);
        check_idle("after reset frame", 1'b0);
        check_idx("after reset frame", 1'b1);
    endtask

    initial begin
        reset      = 1'b1;
        x          = 11'd0;
        y          = 10'd0;
        valid      = 1'b0;
        read_index = 1'b0;
        fill(8'h80);
        test_reset(500, 300);
        test_flat();
        test_ramp();
        test_row_start();
        test_index_toggle();
        test_idle();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
